// File: rtl/m68k_bus_host.sv
// 68000-style bus initiator: runs S0..S7 read/write cycles from a request port
// and hands the bus over via BR/BG/BGACK. Optional BERR_TIMEOUT_EN adds a DTACK timeout abort.
module m68k_bus_host #(
    parameter int CLKDIV  = 7,
    parameter int TIMEOUT = 64
) (
    input  logic        MCLK,
    input  logic        SRES,
    input  logic        req,
    input  logic        req_we,
    input  logic [22:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_uds,
    input  logic        req_lds,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        AS_o,
    output logic        UDS_o,
    output logic        LDS_o,
    output logic        RW_o,
    output logic        strobe_d,
    output logic [22:0] VA_o,
    output logic        VA_d,
    input  logic [15:0] VD_i,
    output logic [15:0] VD_o,
    output logic        VD_d,
    input  logic        AS_i,
    input  logic        DTACK_i,
    input  logic        BR_i,
    input  logic        BGACK_i,
    output logic        BG
);

`ifdef BERR_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int PW         = $clog2(CLKDIV);
    localparam int FALL_PHASE = CLKDIV / 2;
    localparam int TW         = $clog2(TIMEOUT + 2);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7,
        ST_GRANT,
        ST_RELEASED,
        ST_REDRIVE
    } state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] phase_reg;
    logic          rise_tick, fall_tick, any_tick;

    logic          as_reg, as_next;
    logic          uds_reg, uds_next;
    logic          lds_reg, lds_next;
    logic          rw_reg, rw_next;
    logic          strobe_d_reg, strobe_d_next;
    logic [22:0]   va_reg, va_next;
    logic          va_d_reg, va_d_next;
    logic [15:0]   vd_o_reg, vd_o_next;
    logic          vd_d_reg, vd_d_next;
    logic          bg_reg, bg_next;
    logic          ack_reg, ack_next;
    logic          err_reg, err_next;
    logic [15:0]   rdata_reg, rdata_next;
    logic          busy_reg, busy_next;

    logic          cyc_we_reg, cyc_we_next;
    logic [22:0]   cyc_addr_reg, cyc_addr_next;
    logic [15:0]   cyc_wdata_reg, cyc_wdata_next;
    logic          cyc_uds_reg, cyc_uds_next;
    logic          cyc_lds_reg, cyc_lds_next;
    logic          abort_reg, abort_next;
    logic [TW-1:0] wait_cnt_reg, wait_cnt_next;

    // Free-running CPU clock phase; the two ticks are the only moments anything changes.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            phase_reg <= '0;
        end else if (phase_reg == PW'(CLKDIV - 1)) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_reg + PW'(1);
        end
    end

    assign rise_tick = (phase_reg == '0);
    assign fall_tick = (phase_reg == PW'(FALL_PHASE));
    assign any_tick  = rise_tick || fall_tick;

    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            state_reg     <= ST_IDLE;
            as_reg        <= 1'b1;
            uds_reg       <= 1'b1;
            lds_reg       <= 1'b1;
            rw_reg        <= 1'b1;
            strobe_d_reg  <= 1'b0;
            va_reg        <= '0;
            va_d_reg      <= 1'b0;
            vd_o_reg      <= '0;
            vd_d_reg      <= 1'b1;
            bg_reg        <= 1'b1;
            ack_reg       <= 1'b0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
            busy_reg      <= 1'b0;
            cyc_we_reg    <= 1'b0;
            cyc_addr_reg  <= '0;
            cyc_wdata_reg <= '0;
            cyc_uds_reg   <= 1'b0;
            cyc_lds_reg   <= 1'b0;
            abort_reg     <= 1'b0;
            wait_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            as_reg        <= as_next;
            uds_reg       <= uds_next;
            lds_reg       <= lds_next;
            rw_reg        <= rw_next;
            strobe_d_reg  <= strobe_d_next;
            va_reg        <= va_next;
            va_d_reg      <= va_d_next;
            vd_o_reg      <= vd_o_next;
            vd_d_reg      <= vd_d_next;
            bg_reg        <= bg_next;
            ack_reg       <= ack_next;
            err_reg       <= err_next;
            rdata_reg     <= rdata_next;
            busy_reg      <= busy_next;
            cyc_we_reg    <= cyc_we_next;
            cyc_addr_reg  <= cyc_addr_next;
            cyc_wdata_reg <= cyc_wdata_next;
            cyc_uds_reg   <= cyc_uds_next;
            cyc_lds_reg   <= cyc_lds_next;
            abort_reg     <= abort_next;
            wait_cnt_reg  <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        as_next        = as_reg;
        uds_next       = uds_reg;
        lds_next       = lds_reg;
        rw_next        = rw_reg;
        strobe_d_next  = strobe_d_reg;
        va_next        = va_reg;
        va_d_next      = va_d_reg;
        vd_o_next      = vd_o_reg;
        vd_d_next      = vd_d_reg;
        bg_next        = bg_reg;
        ack_next       = 1'b0;
        err_next       = 1'b0;
        rdata_next     = rdata_reg;
        cyc_we_next    = cyc_we_reg;
        cyc_addr_next  = cyc_addr_reg;
        cyc_wdata_next = cyc_wdata_reg;
        cyc_uds_next   = cyc_uds_reg;
        cyc_lds_next   = cyc_lds_reg;
        abort_next     = abort_reg;
        wait_cnt_next  = wait_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                // A bus request beats a pending transfer on the same tick.
                if (rise_tick) begin
                    if (!BR_i) begin
                        bg_next    = 1'b0;
                        state_next = ST_GRANT;
                    end else if (req) begin
                        cyc_we_next    = req_we;
                        cyc_addr_next  = req_addr;
                        cyc_wdata_next = req_wdata;
                        cyc_uds_next   = req_uds;
                        cyc_lds_next   = req_lds;
                        abort_next     = 1'b0;
                        rw_next        = ~req_we;
                        state_next     = ST_S0;
                    end
                end
            end
            ST_S0: begin
                if (fall_tick) begin
                    va_next    = cyc_addr_reg;
                    state_next = ST_S1;
                end
            end
            ST_S1: begin
                if (rise_tick) begin
                    as_next = 1'b0;
                    if (!cyc_we_reg) begin
                        uds_next = ~cyc_uds_reg;
                        lds_next = ~cyc_lds_reg;
                    end
                    state_next = ST_S2;
                end
            end
            ST_S2: begin
                if (fall_tick) begin
                    if (cyc_we_reg) begin
                        vd_d_next = 1'b0;
                        vd_o_next = cyc_wdata_reg;
                    end
                    state_next = ST_S3;
                end
            end
            ST_S3: begin
                if (rise_tick) begin
                    if (cyc_we_reg) begin
                        uds_next = ~cyc_uds_reg;
                        lds_next = ~cyc_lds_reg;
                    end
                    wait_cnt_next = '0;
                    state_next    = ST_S4;
                end
            end
            ST_S4: begin
                // wait_cnt counts ticks spent in S4 before the current one.
                if (fall_tick && !DTACK_i) begin
                    state_next = ST_S5;
                end else if (TIMEOUT_EN && fall_tick && (wait_cnt_reg >= TW'(TIMEOUT))) begin
                    abort_next = 1'b1;
                    as_next    = 1'b1;
                    uds_next   = 1'b1;
                    lds_next   = 1'b1;
                    vd_d_next  = 1'b1;
                    state_next = ST_S7;
                end else if (TIMEOUT_EN && any_tick && (wait_cnt_reg != '1)) begin
                    wait_cnt_next = wait_cnt_reg + TW'(1);
                end
            end
            ST_S5: begin
                if (rise_tick) begin
                    state_next = ST_S6;
                end
            end
            ST_S6: begin
                if (fall_tick) begin
                    if (!cyc_we_reg) begin
                        rdata_next = VD_i;
                    end
                    as_next    = 1'b1;
                    uds_next   = 1'b1;
                    lds_next   = 1'b1;
                    vd_d_next  = 1'b1;
                    state_next = ST_S7;
                end
            end
            ST_S7: begin
                if (rise_tick) begin
                    ack_next   = 1'b1;
                    err_next   = abort_reg;
                    rw_next    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (rise_tick) begin
                    if (!BGACK_i && AS_i) begin
                        strobe_d_next = 1'b1;
                        va_d_next     = 1'b1;
                        vd_d_next     = 1'b1;
                        state_next    = ST_RELEASED;
                    end else if (BR_i && BGACK_i) begin
                        bg_next    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_RELEASED: begin
                if (rise_tick && BGACK_i) begin
                    bg_next       = 1'b1;
                    strobe_d_next = 1'b0;
                    va_d_next     = 1'b0;
                    as_next       = 1'b1;
                    uds_next      = 1'b1;
                    lds_next      = 1'b1;
                    rw_next       = 1'b1;
                    state_next    = ST_REDRIVE;
                end
            end
            ST_REDRIVE: begin
                // One full CPU clock of driven-high strobes before the next cycle may start.
                if (rise_tick) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy_next = (state_next != ST_IDLE) || (req && !ack_next);

    assign ack      = ack_reg;
    assign err      = err_reg;
    assign rdata    = rdata_reg;
    assign busy     = busy_reg;
    assign AS_o     = as_reg;
    assign UDS_o    = uds_reg;
    assign LDS_o    = lds_reg;
    assign RW_o     = rw_reg;
    assign strobe_d = strobe_d_reg;
    assign VA_o     = va_reg;
    assign VA_d     = va_d_reg;
    assign VD_o     = vd_o_reg;
    assign VD_d     = vd_d_reg;
    assign BG       = bg_reg;

endmodule

// File: tb/tb_m68k_bus_host.sv
// Directed testbench for m68k_bus_host (CLKDIV=7, TIMEOUT=8); edge indices n count
// MCLK edges from the tick on which a cycle starts (n=1 is the start tick).
module tb_m68k_bus_host;

    localparam int CLKDIV = 7;

    logic        MCLK;
    logic        SRES;
    logic        req;
    logic        req_we;
    logic [22:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_uds;
    logic        req_lds;
    logic        ack;
    logic [15:0] rdata;
    logic        err;
    logic        busy;
    logic        AS_o;
    logic        UDS_o;
    logic        LDS_o;
    logic        RW_o;
    logic        strobe_d;
    logic [22:0] VA_o;
    logic        VA_d;
    logic [15:0] VD_i;
    logic [15:0] VD_o;
    logic        VD_d;
    logic        AS_i;
    logic        DTACK_i;
    logic        BR_i;
    logic        BGACK_i;
    logic        BG;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int base   = 0;

    m68k_bus_host #(
        .CLKDIV (CLKDIV),
        .TIMEOUT(8)
    ) dut (
        .MCLK     (MCLK),
        .SRES     (SRES),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_uds  (req_uds),
        .req_lds  (req_lds),
        .ack      (ack),
        .rdata    (rdata),
        .err      (err),
        .busy     (busy),
        .AS_o     (AS_o),
        .UDS_o    (UDS_o),
        .LDS_o    (LDS_o),
        .RW_o     (RW_o),
        .strobe_d (strobe_d),
        .VA_o     (VA_o),
        .VA_d     (VA_d),
        .VD_i     (VD_i),
        .VD_o     (VD_o),
        .VD_d     (VD_d),
        .AS_i     (AS_i),
        .DTACK_i  (DTACK_i),
        .BR_i     (BR_i),
        .BGACK_i  (BGACK_i),
        .BG       (BG)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    always @(posedge MCLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    // Leaves the bench #1 after the edge that precedes a rise tick.
    task automatic sync_rise();
        for (int i = 0; i < 2 * CLKDIV; i++) begin
            if ((cyc - base) % CLKDIV == CLKDIV - 1) break;
            step();
        end
    endtask

    task automatic release_reset();
        @(negedge MCLK);
        SRES = 1'b1;
        step();
        base = cyc;
    endtask

    task automatic test_reset();
        logic [10:0] flags;
        SRES = 1'b0;
        repeat (3) step();
        flags = {AS_o, UDS_o, LDS_o, RW_o, strobe_d, VA_d, VD_d, BG, ack, err, busy};
        checks++;
        if (flags !== 11'b11110011000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected %b", flags, 11'b11110011000);
        end
        checks++;
        if (VA_o !== 23'h0 || VD_o !== 16'h0 || rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: VA_o=%h VD_o=%h rdata=%h expected all zero", VA_o, VD_o, rdata);
        end
        release_reset();
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0 || AS_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: busy=%b ack=%b AS_o=%b expected 0 0 1", busy, ack, AS_o);
        end
        $display("reset done");
    endtask

    task automatic test_read(input logic [22:0] addr, input logic [15:0] data);
        int lat, as_low, ds_low, rw_low;
        lat = -1; as_low = 0; ds_low = 0; rw_low = 0;
        VD_i = data;
        DTACK_i = 1'b0;
        sync_rise();
        req = 1'b1; req_we = 1'b0; req_addr = addr; req_wdata = 16'h0;
        req_uds = 1'b1; req_lds = 1'b1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            step();
            if (AS_o === 1'b0) as_low++;
            if (UDS_o === 1'b0 && LDS_o === 1'b0) ds_low++;
            if (RW_o === 1'b0) rw_low++;
            if (n == 5) begin
                checks++;
                if (busy !== 1'b1 || VA_o !== addr) begin
                    errors++;
                    $display("FAIL read_mid: busy=%b VA_o=%h expected busy=1 VA_o=%h", busy, VA_o, addr);
                end
            end
            if (ack === 1'b1) lat = n - 1;
        end
        checks++;
        if (lat != 28) begin
            errors++;
            $display("FAIL read_latency: got %0d MCLK expected 28", lat);
        end
        checks++;
        if (rdata !== data || err !== 1'b0) begin
            errors++;
            $display("FAIL read_data: rdata=%h err=%b expected rdata=%h err=0", rdata, err, data);
        end
        req = 1'b0;
        step();
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL read_ack_pulse: ack=%b one MCLK after ack expected 0", ack);
        end
        checks++;
        if (as_low != 17 || ds_low != 17 || rw_low != 0) begin
            errors++;
            $display("FAIL read_strobes: as_low=%0d ds_low=%0d rw_low=%0d expected 17 17 0",
                     as_low, ds_low, rw_low);
        end
        $display("read  addr=%06h data=%04h rdata=%04h lat=%0d", addr, data, rdata, lat);
    endtask

    task automatic test_write();
        int lat, uds_low, lds_low, rw_low, lds_first, vd_first;
        logic vd_d_at;
        lat = -1; uds_low = 0; lds_low = 0; rw_low = 0; lds_first = -1; vd_first = -1;
        vd_d_at = 1'bx;
        DTACK_i = 1'b0;
        sync_rise();
        req = 1'b1; req_we = 1'b1; req_addr = 23'h7F0000; req_wdata = 16'h1234;
        req_uds = 1'b0; req_lds = 1'b1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            step();
            if (UDS_o === 1'b0) uds_low++;
            if (LDS_o === 1'b0) lds_low++;
            if (RW_o === 1'b0) rw_low++;
            if (LDS_o === 1'b0 && lds_first < 0) lds_first = n;
            if (VD_o === 16'h1234 && vd_first < 0) begin
                vd_first = n;
                vd_d_at = VD_d;
            end
            if (ack === 1'b1) lat = n - 1;
        end
        req = 1'b0;
        checks++;
        if (lat != 28 || VA_o !== 23'h7F0000) begin
            errors++;
            $display("FAIL write_latency: lat=%0d VA_o=%h expected 28 7f0000", lat, VA_o);
        end
        checks++;
        if (uds_low != 0 || lds_first != 15 || lds_low != 10) begin
            errors++;
            $display("FAIL write_strobes: uds_low=%0d lds_first=%0d lds_low=%0d expected 0 15 10",
                     uds_low, lds_first, lds_low);
        end
        checks++;
        if (vd_first != 11 || vd_d_at !== 1'b0) begin
            errors++;
            $display("FAIL write_data: vd_first=%0d VD_d=%b expected 11 0", vd_first, vd_d_at);
        end
        checks++;
        if (rw_low != 28 || RW_o !== 1'b1 || VD_d !== 1'b1) begin
            errors++;
            $display("FAIL write_rw: rw_low=%0d RW_o=%b VD_d=%b expected 28 1 1", rw_low, RW_o, VD_d);
        end
        step();
        $display("write addr=7f0000 data=1234 lds_only lat=%0d", lat);
    endtask

    task automatic test_wait_states();
        int lat, as_low, va_bad;
        lat = -1; as_low = 0; va_bad = 0;
        VD_i = 16'h5AA5;
        DTACK_i = 1'b1;
        sync_rise();
        req = 1'b1; req_we = 1'b0; req_addr = 23'h0ABCDE; req_uds = 1'b1; req_lds = 1'b1;
        for (int n = 1; n <= 70 && lat < 0; n++) begin
            step();
            if (n == 35) DTACK_i = 1'b0;
            if (AS_o === 1'b0) as_low++;
            if (n >= 4 && VA_o !== 23'h0ABCDE) va_bad++;
            if (ack === 1'b1) lat = n - 1;
        end
        req = 1'b0;
        checks++;
        if (lat != 49) begin
            errors++;
            $display("FAIL wait_latency: got %0d MCLK expected 49", lat);
        end
        checks++;
        if (rdata !== 16'h5AA5) begin
            errors++;
            $display("FAIL wait_data: rdata=%h expected 5aa5", rdata);
        end
        checks++;
        if (as_low != 38 || va_bad != 0) begin
            errors++;
            $display("FAIL wait_stable: as_low=%0d va_bad=%0d expected 38 0", as_low, va_bad);
        end
        step();
        $display("read  addr=0abcde waits=3 rdata=%04h lat=%0d", rdata, lat);
    endtask

    task automatic test_bus_arbitration();
        int ack1, ack2, bg_fall;
        ack1 = -1; ack2 = -1; bg_fall = -1;
        VD_i = 16'h1111;
        DTACK_i = 1'b0;
        sync_rise();
        req = 1'b1; req_we = 1'b0; req_addr = 23'h000100; req_uds = 1'b1; req_lds = 1'b1;
        for (int n = 1; n <= 110 && ack2 < 0; n++) begin
            step();
            if (n == 10) BR_i = 1'b0;
            if (BG === 1'b0 && bg_fall < 0) bg_fall = n;
            if (ack === 1'b1) begin
                if (ack1 < 0) begin
                    ack1 = n;
                    checks++;
                    if (BG !== 1'b1 || rdata !== 16'h1111) begin
                        errors++;
                        $display("FAIL arb_first_ack: BG=%b rdata=%h expected 1 1111", BG, rdata);
                    end
                    req_addr = 23'h000200;
                    VD_i = 16'h0F0F;
                end else begin
                    ack2 = n;
                    req = 1'b0;
                end
            end
            if (n == 37) BGACK_i = 1'b0;
            if (n == 43) begin
                checks++;
                if ({strobe_d, VA_d, VD_d, BG, busy} !== 5'b11101) begin
                    errors++;
                    $display("FAIL arb_released: {strobe_d,VA_d,VD_d,BG,busy}=%b expected 11101",
                             {strobe_d, VA_d, VD_d, BG, busy});
                end
            end
            if (n == 46) begin
                BR_i = 1'b1;
                BGACK_i = 1'b1;
            end
            if (n == 50) begin
                checks++;
                if ({BG, strobe_d, VA_d, AS_o} !== 4'b1001) begin
                    errors++;
                    $display("FAIL arb_return: {BG,strobe_d,VA_d,AS_o}=%b expected 1001",
                             {BG, strobe_d, VA_d, AS_o});
                end
            end
        end
        req = 1'b0;
        checks++;
        if (ack1 != 29 || bg_fall != 36) begin
            errors++;
            $display("FAIL arb_grant_timing: ack1=%0d bg_fall=%0d expected 29 36", ack1, bg_fall);
        end
        checks++;
        if (ack2 != 92 || rdata !== 16'h0F0F) begin
            errors++;
            $display("FAIL arb_pending_req: ack2=%0d rdata=%h expected 92 0f0f", ack2, rdata);
        end
        step();
        $display("arb   ack1=%0d bg_fall=%0d ack2=%0d rdata=%04h", ack1, bg_fall, ack2, rdata);
    endtask

    task automatic test_reset_mid_cycle();
        int acks;
        acks = 0;
        DTACK_i = 1'b0;
        sync_rise();
        req = 1'b1; req_we = 1'b1; req_addr = 23'h000300; req_wdata = 16'h4444;
        req_uds = 1'b1; req_lds = 1'b1;
        for (int n = 1; n <= 19; n++) begin
            step();
            if (ack === 1'b1) acks++;
        end
        checks++;
        if (AS_o !== 1'b0 || VD_d !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_pre: AS_o=%b VD_d=%b expected 0 0", AS_o, VD_d);
        end
        SRES = 1'b0;
        req = 1'b0;
        #1;
        checks++;
        if ({AS_o, UDS_o, LDS_o, RW_o, VD_d, strobe_d, BG} !== 7'b1111101) begin
            errors++;
            $display("FAIL mid_reset_outputs: {AS,UDS,LDS,RW,VD_d,strobe_d,BG}=%b expected 1111101",
                     {AS_o, UDS_o, LDS_o, RW_o, VD_d, strobe_d, BG});
        end
        for (int n = 0; n < 10; n++) begin
            step();
            if (ack === 1'b1) acks++;
        end
        release_reset();
        for (int n = 0; n < 40; n++) begin
            step();
            if (ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL mid_reset_no_ack: saw %0d ack pulses expected 0", acks);
        end
        $display("write addr=000300 aborted by reset acks=%0d", acks);
    endtask

`ifdef BERR_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        logic [15:0] prev;
        logic err_at_ack;
        lat = -1;
        err_at_ack = 1'b0;
        prev = rdata;
        VD_i = 16'h7777;
        DTACK_i = 1'b1;
        sync_rise();
        req = 1'b1; req_we = 1'b0; req_addr = 23'h000400; req_uds = 1'b1; req_lds = 1'b1;
        for (int n = 1; n <= 80 && lat < 0; n++) begin
            step();
            if (ack === 1'b1) begin
                lat = n - 1;
                err_at_ack = err;
            end
        end
        req = 1'b0;
        checks++;
        if (lat != 49 || err_at_ack !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ack: lat=%0d err=%b expected 49 1", lat, err_at_ack);
        end
        checks++;
        if (rdata !== prev) begin
            errors++;
            $display("FAIL timeout_rdata: rdata=%h expected unchanged %h", rdata, prev);
        end
        step();
        checks++;
        if (err !== 1'b0 || AS_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: err=%b AS_o=%b expected 0 1", err, AS_o);
        end
        DTACK_i = 1'b0;
        $display("read  addr=000400 timeout lat=%0d err=%b", lat, err_at_ack);
    endtask
`endif

    initial begin
        SRES = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_uds = 1'b0; req_lds = 1'b0; VD_i = '0; AS_i = 1'b1; DTACK_i = 1'b0;
        BR_i = 1'b1; BGACK_i = 1'b1;
        test_reset();
        test_read(23'h000100, 16'hA55A);
        test_write();
        test_wait_states();
        test_bus_arbitration();
        test_reset_mid_cycle();
        test_read(23'h000500, 16'hC3C3);
`ifdef BERR_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m68k_bus_host.md
Name: m68k_bus_host

Overview:
- Synthesizable 68000-style bus initiator. It runs the host side of the 68k bus that the FC1004 gate array answers: it drives AS/UDS/LDS/RW/VA/VD and waits for DTACK.
- A simple request port issues word or byte reads and writes. The block also services BR/BG/BGACK so the VDP DMA and Z80 bus arbitration can take the bus.
- Intended as a CPU replacement for system-level benches and for CPU-less FPGA builds.

Parameters:
- CLKDIV, 7: MCLK cycles per CPU clock. Minimum 4.
- TIMEOUT, 64: half-clock ticks allowed in S4 waits before the bus-error abort. Used only with BERR_TIMEOUT_EN.

Ports:
- MCLK  in  1  single system clock
- SRES  in  1  asynchronous reset, active-low
- req  in  1  request. Held until ack.
- req_we  in  1  1 = write, 0 = read
- req_addr  in  23  word address, driven on VA[22:0]
- req_wdata  in  16  write data
- req_uds, req_lds  in  1 each  byte enables, active-high
- ack  out  1  one-MCLK pulse at cycle end
- rdata  out  16  read data, valid from the ack pulse until the next ack
- err  out  1  with ack: cycle aborted (timeout)
- busy  out  1  cycle in progress, or bus not owned
- AS_o, UDS_o, LDS_o, RW_o  out  1 each  strobe levels (active-low; RW 1 = read)
- strobe_d  out  1  1 = strobes and RW released (input), 0 = driven
- VA_o  out  23  address
- VA_d  out  1  address direction (1 = input)
- VD_i  in  16  data in
- VD_o  out  16  data out
- VD_d  out  1  data direction (1 = input)
- AS_i  in  1  sensed AS, used for arbitration
- DTACK_i  in  1  active-low
- BR_i  in  1  active-low
- BGACK_i  in  1  active-low
- BG  out  1  active-low

Behaviour:
- Phase counter 0..CLKDIV-1.
  - Rise tick at count 0; fall tick at count CLKDIV/2 (integer division).
  - All state changes and input sampling happen on ticks only. Even S-states start on rise ticks, odd S-states on fall ticks.
- Reset values: AS/UDS/LDS/RW_o=1; strobe_d=0; VA_o=0; VA_d=0; VD_o=0; VD_d=1; BG=1; ack=0; err=0; rdata=0; busy=0; phase=0; state IDLE.
- IDLE:
  - On a rise tick with req=1 and the bus owned, latch the request and enter S0.
  - If BR_i is low on that tick, arbitration wins and the request stays pending.
- S0: RW_o = ~req_we.
- S1: VA_o = latched address.
- S2: AS_o=0. For a read, UDS_o/LDS_o = ~enables.
- S3: for a write, VD_d=0 and VD_o = wdata.
- S4: for a write, UDS_o/LDS_o = ~enables.
  - DTACK_i is sampled on the fall tick that ends S4.
  - If DTACK_i=1, insert two ticks (one wait state) and resample.
  - If DTACK_i=0, go to S5.
- S5: no action.
- S6: VD_i is captured into rdata on the fall tick ending S6.
- S7: AS/UDS/LDS_o=1; VD_d=1. On the rise tick ending S7, pulse ack and return to IDLE; RW_o=1.
- Zero-wait cycle: 8 ticks = 4 CPU clocks. Each wait adds 1 CPU clock.
- Arbitration:
  - BR_i low sampled on a rise tick in IDLE: BG=0, enter GRANT.
  - In GRANT, when BGACK_i=0 and AS_i=1 on a rise tick: strobe_d=1, VA_d=1, VD_d=1, enter RELEASED.
  - If BR_i returns high in GRANT before BGACK_i falls: BG=1, back to IDLE.
  - In RELEASED, BGACK_i high on a rise tick: BG=1, re-drive the strobes high, IDLE on the next rise tick.
  - BR_i asserted mid-cycle does not stop the cycle. It is serviced after S7.
- busy = (state != IDLE) or req pending.
- Async SRES mid-cycle: outputs go to their reset values immediately. No ack is issued.
- Deasserting req mid-cycle is ignored; ack still pulses.

Optional Feature:
- BERR_TIMEOUT_EN defined:
  - A counter runs during S4 waits.
  - After TIMEOUT ticks without DTACK, jump to S7 and release.
  - ack and err both pulse; rdata is left unchanged.
- BERR_TIMEOUT_EN undefined: waits are unbounded; err is tied to 0.

Test Plan:
- Read, addr 0x000100, both enables, DTACK tied low, VD_i=0xA55A, CLKDIV=7 -> ack 28 MCLK after the start tick, rdata=0xA55A, AS low for S2..S7.
- Write 0x1234 to 0x7F0000, LDS only -> UDS_o stays 1, LDS_o falls on the S4 tick, VD_o=0x1234 from S3, RW_o=0 from S0 to S7.
- DTACK delayed 3 wait states -> ack at 28+21 MCLK; VA/AS stable throughout.
- BR_i low during a cycle -> BG falls only after ack. BGACK_i low -> strobe_d/VA_d/VD_d=1. BGACK_i high -> BG=1; the pending req then runs.
- SRES low at S5 -> AS_o=1, VD_d=1 immediately, no ack. After release, the next req completes normally.
- BERR_TIMEOUT_EN, TIMEOUT=8, DTACK held high -> ack with err=1 after 8 wait ticks, rdata unchanged.
